d_ff_response_checker: RTL and testbench

- Synthesizable self-checking monitor for the D flip-flop: the receiving end of the stimulus/response path.
- Passively observes the DUT's d, reset, q and qb each clock.
- Keeps a reference model of the expected q and flags any mismatch.
- Used in benches and on-chip bring-up next to the D flip-flop, so the DUT's output side is checked in hardware instead of by waveform inspection.

---
 rtl/d_ff_check_pkg.sv | 16 +
 rtl/d_ff_response_checker_sat_counter.sv | 21 ++
 rtl/d_ff_response_checker.sv | 122 ++++++++++++
 tb/tb_d_ff_response_checker.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/d_ff_check_pkg.sv
// Shared types and constants for the D flip-flop response checker.
// Holds the checker FSM encoding and the counter width defaults.
package d_ff_check_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam int CNT_W_DEF = 16;

    localparam logic [CNT_W_DEF-1:0] CNT_SAT = '1;

endpackage

// File: rtl/d_ff_response_checker_sat_counter.sv
// Saturating up-counter used for the check and error tallies.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // count up on inc, stick at the maximum value
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/d_ff_response_checker.sv
// Passive monitor checking a D flip-flop's q/qb against a reference model.
// Optional capture of the last failing check under D_FF_CHECK_TRACE_EN.
module d_ff_response_checker
    import d_ff_check_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dut_rst,
    input  logic             d_obs,
    input  logic             q_obs,
    input  logic             qb_obs,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] check_count,
    output logic [1:0]       state
`ifdef D_FF_CHECK_TRACE_EN
    ,
    output logic [CNT_W-1:0] last_err_idx,
    output logic             last_err_q,
    output logic             last_err_qb
`endif
);

    state_t state_r;
    state_t state_nx;
    logic   exp_q;
    logic   chk;
    logic   fail;
    logic   hit;

    assign state = state_r;

    // A check runs in every RUN cycle; the registered state decides,
    // so the cycle in which en drops still gets checked.
    assign chk  = (state_r == RUN);
    assign fail = (q_obs != exp_q) || (qb_obs == q_obs);
    assign hit  = chk && fail;

    // next-state logic
    always_comb begin
        state_nx = state_r;
        unique case (state_r)
            IDLE: if (en) state_nx = ARM;
            ARM:  state_nx = en ? RUN : IDLE;
            RUN: begin
                if (hit && STOP_ON_ERR) begin
                    state_nx = HALT;
                end else if (!en) begin
                    state_nx = IDLE;
                end
            end
            HALT:    state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // reference DFF with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q <= 1'b0;
        end else begin
            exp_q <= dut_rst ? 1'b0 : d_obs;
        end
    end

    // error pulse and sticky flag
    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            err_pulse <= hit;
            if (hit) begin
                err_sticky <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_check_cnt (
        .clk (clk),
        .rst (rst),
        .inc (chk),
        .cnt (check_count)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit),
        .cnt (err_count)
    );

`ifdef D_FF_CHECK_TRACE_EN
    // capture index and observed outputs of the latest failing check
    always_ff @(posedge clk) begin
        if (rst) begin
            last_err_idx <= '0;
            last_err_q   <= 1'b0;
            last_err_qb  <= 1'b0;
        end else if (hit) begin
            last_err_idx <= check_count;
            last_err_q   <= q_obs;
            last_err_qb  <= qb_obs;
        end
    end
`endif

endmodule

// File: tb/tb_d_ff_response_checker.sv
// Directed bench for d_ff_response_checker: three instances (default,
// stop-on-error, 3-bit counters) checked every cycle against a model.
module tb_d_ff_response_checker;

    logic clk     = 1'b0;
    logic rst     = 1'b1;
    logic en      = 1'b0;
    logic dut_rst = 1'b1;
    logic d_obs   = 1'b0;
    logic q_obs   = 1'b0;
    logic qb_obs  = 1'b1;

    int tests = 0;
    int fails = 0;

    logic [15:0] ec [3];
    logic [15:0] cc [3];
    logic [1:0]  st [3];
    logic        ep [3];
    logic        es [3];
    logic [15:0] ti [3];
    logic        tq [3];
    logic        tqb[3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 2) ? 3 : 16;
        localparam bit S = (g == 1);
        logic [W-1:0] ecl;
        logic [W-1:0] ccl;
        logic         pl;
        logic         sl;
        logic [1:0]   stl;
`ifdef D_FF_CHECK_TRACE_EN
        logic [W-1:0] til;
        logic         tql;
        logic         tqbl;
`endif
        d_ff_response_checker #(.CNT_W(W), .STOP_ON_ERR(S)) u (
            .clk         (clk),
            .rst         (rst),
            .en          (en),
            .dut_rst     (dut_rst),
            .d_obs       (d_obs),
            .q_obs       (q_obs),
            .qb_obs      (qb_obs),
            .err_pulse   (pl),
            .err_sticky  (sl),
            .err_count   (ecl),
            .check_count (ccl),
            .state       (stl)
`ifdef D_FF_CHECK_TRACE_EN
            ,
            .last_err_idx(til),
            .last_err_q  (tql),
            .last_err_qb (tqbl)
`endif
        );
        assign ec[g] = 16'(ecl);
        assign cc[g] = 16'(ccl);
        assign ep[g] = pl;
        assign es[g] = sl;
        assign st[g] = stl;
`ifdef D_FF_CHECK_TRACE_EN
        assign ti[g]  = 16'(til);
        assign tq[g]  = tql;
        assign tqb[g] = tqbl;
`else
        assign ti[g]  = 16'd0;
        assign tq[g]  = 1'b0;
        assign tqb[g] = 1'b0;
`endif
    end

    function automatic void chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic int maxv(int i);
        return (i == 2) ? 7 : 65535;
    endfunction

    // behavioural model: what each checker must show after every edge
    int m_st [3] = '{0, 0, 0};
    int m_cc [3] = '{0, 0, 0};
    int m_ec [3] = '{0, 0, 0};
    int m_ti [3] = '{0, 0, 0};
    bit m_p  [3];
    bit m_s  [3];
    bit m_x  [3];
    bit m_tq [3];
    bit m_tqb[3];

    initial begin
        bit c;
        bit f;
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) begin
                c = (m_st[i] == 2);
                f = c && ((q_obs !== m_x[i]) || (qb_obs === q_obs));
                if (rst) begin
                    m_st[i] = 0; m_cc[i] = 0; m_ec[i] = 0;
                    m_p[i] = 0; m_s[i] = 0;
                    m_ti[i] = 0; m_tq[i] = 0; m_tqb[i] = 0;
                end else begin
                    m_p[i] = f;
                    if (f) begin
                        m_s[i]   = 1;
                        m_ti[i]  = m_cc[i];
                        m_tq[i]  = q_obs;
                        m_tqb[i] = qb_obs;
                    end
                    if (c && m_cc[i] < maxv(i)) m_cc[i]++;
                    if (f && m_ec[i] < maxv(i)) m_ec[i]++;
                    case (m_st[i])
                        0: m_st[i] = en ? 1 : 0;
                        1: m_st[i] = en ? 2 : 0;
                        2: begin
                            if (f && i == 1) m_st[i] = 3;
                            else if (!en)    m_st[i] = 0;
                        end
                        default: m_st[i] = 3;
                    endcase
                end
                m_x[i] = (rst || dut_rst) ? 1'b0 : d_obs;
            end
            #1;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("dut%0d.state", i), int'(st[i]), m_st[i]);
                chk($sformatf("dut%0d.check_count", i), int'(cc[i]), m_cc[i]);
                chk($sformatf("dut%0d.err_count", i), int'(ec[i]), m_ec[i]);
                chk($sformatf("dut%0d.err_pulse", i), int'(ep[i]), int'(m_p[i]));
                chk($sformatf("dut%0d.err_sticky", i), int'(es[i]), int'(m_s[i]));
`ifdef D_FF_CHECK_TRACE_EN
                chk($sformatf("dut%0d.last_err_idx", i), int'(ti[i]), m_ti[i]);
                chk($sformatf("dut%0d.last_err_q", i), int'(tq[i]), int'(m_tq[i]));
                chk($sformatf("dut%0d.last_err_qb", i), int'(tqb[i]), int'(m_tqb[i]));
`endif
            end
        end
    end

    // q of a flip-flop driven by d_obs/dut_rst; fault 3 ignores dut_rst
    logic gq = 1'b0;

    // faults: 0 good, 1 q stuck at 1, 2 qb equals q, 3 no reset
    task automatic step(input logic e, input logic dr, input logic dd,
                        input int fault);
        @(negedge clk);
        rst = 1'b0; en = e; dut_rst = dr; d_obs = dd;
        case (fault)
            1:       begin q_obs = 1'b1; qb_obs = 1'b0; end
            2:       begin q_obs = gq;   qb_obs = gq;   end
            default: begin q_obs = gq;   qb_obs = ~gq;  end
        endcase
        @(posedge clk);
        gq = (fault == 3) ? dd : (dr ? 1'b0 : dd);
        #2;
    endtask

    task automatic reset_all();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; dut_rst = 1'b1; d_obs = 1'b0;
        q_obs = gq; qb_obs = ~gq;
        @(posedge clk);
        gq = 1'b0;
        #2;
    endtask

    task automatic start();
        reset_all();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
    endtask

    initial begin
        // correct DFF, state walk and three clean checks
        reset_all();
        chk("rst.state", int'(st[0]), 0);
        chk("rst.check_count", int'(cc[0]), 0);
        step(1, 0, 0, 0);
        chk("arm.state", int'(st[0]), 1);
        step(1, 0, 0, 0);
        chk("run.state", int'(st[0]), 2);
        step(1, 0, 1, 0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        chk("good.check_count", int'(cc[0]), 3);
        chk("good.err_count", int'(ec[0]), 0);
        chk("good.err_sticky", int'(es[0]), 0);

        // q stuck at 1 while d=0
        start();
        step(1, 0, 0, 1);
        chk("stuck.pulse1", int'(ep[0]), 1);
        step(1, 0, 0, 1);
        chk("stuck.pulse2", int'(ep[0]), 1);
        chk("stuck.err_count", int'(ec[0]), 2);
        chk("stuck.err_sticky", int'(es[0]), 1);
        chk("stop.state", int'(st[1]), 3);
        chk("stop.err_count", int'(ec[1]), 1);
        chk("stop.check_count", int'(cc[1]), 1);
        step(1, 0, 1, 0);
        step(1, 0, 0, 1);
        chk("stop.frozen_cc", int'(cc[1]), 1);
        chk("stop.frozen_ec", int'(ec[1]), 1);
        chk("stop.halt_pulse", int'(ep[1]), 0);
        reset_all();
        chk("stop.rst_state", int'(st[1]), 0);
        chk("stop.rst_sticky", int'(es[1]), 0);
        chk("stop.rst_ec", int'(ec[1]), 0);

        // complement fault on one cycle
        start();
        step(1, 0, 1, 0);
        step(1, 0, 0, 2);
        step(1, 0, 1, 0);
        chk("cmpl.err_count", int'(ec[0]), 1);
        chk("cmpl.check_count", int'(cc[0]), 3);

        // DUT that ignores its reset
        start();
        step(1, 0, 1, 0);
        step(1, 1, 1, 3);
        chk("norst.first", int'(ep[0]), 0);
        step(1, 1, 1, 3);
        chk("norst.second", int'(ep[0]), 1);
        chk("norst.err_count", int'(ec[0]), 1);

        // DUT that clears correctly
        start();
        step(1, 0, 1, 0);
        step(1, 1, 1, 0);
        step(1, 1, 1, 0);
        step(1, 0, 0, 0);
        chk("goodrst.err_count", int'(ec[0]), 0);

        // saturation on the 3-bit instance
        start();
        for (int k = 0; k < 10; k++) step(1, 0, 0, 1);
        chk("sat.err_count", int'(ec[2]), 7);
        chk("sat.check_count", int'(cc[2]), 7);
        chk("sat.pulse", int'(ep[2]), 1);

        // en drops in the same cycle as an error
        start();
        step(0, 0, 0, 1);
        chk("endrop.state", int'(st[0]), 0);
        chk("endrop.err_count", int'(ec[0]), 1);
        chk("endrop.stop_state", int'(st[1]), 3);

        // ARM aborts back to IDLE when en drops
        reset_all();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("armabort.state", int'(st[0]), 0);

        // rst mid-RUN drops a pending pulse
        start();
        step(1, 0, 0, 1);
        chk("midrst.pre", int'(ep[0]), 1);
        reset_all();
        chk("midrst.pulse", int'(ep[0]), 0);
        chk("midrst.cc", int'(cc[0]), 0);

        step(0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
